// File: rtl/fetch_unit_multicycle.sv
// fetch_unit_multicycle: PC/IR fetch stage with a req/ack instruction-memory handshake; define FETCH_TIMEOUT_EN for a fetch timeout with a sticky error flag.
module fetch_unit_multicycle #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PC_enable,
    input  logic               IR_enable,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  pc,
    output logic               instr_valid,
    output logic               fetch_stall,
    output logic               fetch_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;
    logic [0:0]        state;
    logic              taken;
    logic              timeout;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] next_pc;
    assign imem_req    = state == REQ;
    assign fetch_stall = state == REQ;
    assign opcode      = instr[INSTR_W-1 -: 4];
    assign off         = ADDR_W'($signed(instr[7:0]));
    assign taken       = branch && ((opcode == 4'b0111 && zero) || (opcode == 4'b1000 && !zero));
    assign next_pc     = jump ? instr[ADDR_W-1:0] : taken ? pc + ADDR_W'(1) + off : pc + ADDR_W'(1);
`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    assign timeout = state == REQ && !imem_ack && cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            fetch_err <= 1'b0;
        end else begin
            cnt <= (state == REQ && !imem_ack && !timeout) ? cnt + CW'(1) : '0;
            if (timeout) fetch_err <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= ADDR_W'(RESET_PC);
            instr       <= '0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (PC_enable) pc <= next_pc;
            if (state == IDLE) begin
                if (IR_enable) begin
                    state       <= REQ;
                    imem_addr   <= pc;
                    instr_valid <= 1'b0;
                end
            end else if (imem_ack) begin
                state       <= IDLE;
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end else if (timeout) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit_multicycle.sv
// tb_fetch_unit_multicycle: directed test-plan steps then random traffic against a behavioural model.
module tb_fetch_unit_multicycle;
    logic        clk = 1'b0;
    logic        reset, PC_enable, IR_enable, branch, jump, zero, imem_ack;
    logic [15:0] imem_rdata;
    logic        imem_req, instr_valid, fetch_stall, fetch_err;
    logic [7:0]  imem_addr, pc;
    logic [15:0] instr;
    logic [3:0]  opcode;
    int checks = 0, failures = 0;
    logic [7:0]  m_pc, m_addr;
    logic [15:0] m_instr;
    logic        m_busy, m_valid, m_err;
    int          m_wait, reqc;
    localparam int TO = 15;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    fetch_unit_multicycle dut (
        .clk(clk), .reset(reset), .PC_enable(PC_enable), .IR_enable(IR_enable),
        .branch(branch), .jump(jump), .zero(zero), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .pc(pc), .instr_valid(instr_valid),
        .fetch_stall(fetch_stall), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_next_pc();
        int op  = int'(m_instr[15:12]);
        int ofs = m_instr[7] ? int'(m_instr[7:0]) - 256 : int'(m_instr[7:0]);
        if (jump) return m_instr[7:0];
        if (branch && ((op == 7 && zero) || (op == 8 && !zero)))
            return 8'((int'(m_pc) + 257 + ofs) % 256);
        return 8'((int'(m_pc) + 1) % 256);
    endfunction

    task automatic step();
        logic [7:0] npc;
        if (!reset) begin
            m_pc = 8'h00; m_instr = 16'h0; m_addr = 8'h00;
            m_busy = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_wait = 0;
        end else begin
            npc = PC_enable ? ref_next_pc() : m_pc;
            if (!m_busy) begin
                if (IR_enable) begin
                    m_busy = 1'b1; m_addr = m_pc; m_valid = 1'b0; m_wait = 0;
                end
            end else if (imem_ack) begin
                m_busy = 1'b0; m_instr = imem_rdata; m_valid = 1'b1;
            end else if (TO_EN) begin
                m_wait++;
                if (m_wait >= TO) begin
                    m_busy = 1'b0; m_err = 1'b1;
                end
            end
            m_pc = npc;
        end
        @(posedge clk);
        #1;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("instr", 32'(instr), 32'(m_instr));
        chk("opcode", 32'(opcode), 32'(m_instr[15:12]));
        chk("req", 32'(imem_req), 32'(m_busy));
        chk("stall", 32'(fetch_stall), 32'(m_busy));
        chk("valid", 32'(instr_valid), 32'(m_valid));
        chk("err", 32'(fetch_err), 32'(m_err));
        if (m_busy) chk("addr", 32'(imem_addr), 32'(m_addr));
    endtask

    task automatic fetch(input logic [15:0] data);
        IR_enable = 1'b1; step(); IR_enable = 1'b0;
        step();
        imem_ack = 1'b1; imem_rdata = data; step();
        imem_ack = 1'b0; imem_rdata = 16'($urandom);
    endtask

    task automatic set_pc(input logic [7:0] v);
        fetch({8'hB0, v});
        jump = 1'b1; PC_enable = 1'b1; step();
        jump = 1'b0; PC_enable = 1'b0;
    endtask

    task automatic pc_op(input logic b, input logic z);
        branch = b; zero = z; PC_enable = 1'b1; step();
        branch = 1'b0; zero = 1'b0; PC_enable = 1'b0;
    endtask

    initial begin
        reset = 1'b0; PC_enable = 1'b0; IR_enable = 1'b0; branch = 1'b0;
        jump = 1'b0; zero = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0;
        step(); step();
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'h00);
        reset = 1'b1;

        IR_enable = 1'b1; step(); IR_enable = 1'b0;
        chk("f1_addr", 32'(imem_addr), 32'h00);
        reqc = int'(imem_req);
        step(); reqc += int'(imem_req);
        step(); reqc += int'(imem_req);
        imem_ack = 1'b1; imem_rdata = 16'h9123; step(); imem_ack = 1'b0;
        chk("f1_req_cycles", 32'(reqc), 32'd3);
        chk("f1_instr", 32'(instr), 32'h9123);
        chk("f1_opcode", 32'(opcode), 32'h9);
        chk("f1_valid", 32'(instr_valid), 32'h1);
        chk("f1_req_low", 32'(imem_req), 32'h0);

        set_pc(8'h10); fetch(16'h7005); pc_op(1'b1, 1'b1);
        chk("beq_taken", 32'(pc), 32'h16);
        set_pc(8'h10); fetch(16'h7005); pc_op(1'b1, 1'b0);
        chk("beq_not_taken", 32'(pc), 32'h11);
        set_pc(8'h10); fetch(16'h80FE); pc_op(1'b1, 1'b0);
        chk("bne_back", 32'(pc), 32'h0F);
        fetch(16'hB0A4); jump = 1'b1; pc_op(1'b0, 1'b0); jump = 1'b0;
        chk("jump", 32'(pc), 32'hA4);
        set_pc(8'hFF); pc_op(1'b0, 1'b0);
        chk("wrap", 32'(pc), 32'h00);

        set_pc(8'h20);
        IR_enable = 1'b1; PC_enable = 1'b1; step(); IR_enable = 1'b0; PC_enable = 1'b0;
        chk("same_cycle_addr", 32'(imem_addr), 32'h20);
        chk("same_cycle_pc", 32'(pc), 32'h21);
        pc_op(1'b0, 1'b0);
        chk("pc_in_req_addr", 32'(imem_addr), 32'h20);
        imem_ack = 1'b1; imem_rdata = 16'h1111; step(); imem_ack = 1'b0;

        IR_enable = 1'b1; step(); IR_enable = 1'b0; step();
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hFFFF; step();
        imem_ack = 1'b0; reset = 1'b1;
        chk("rst_req_mid", 32'(imem_req), 32'h0);
        chk("rst_instr_mid", 32'(instr), 32'h0);
        chk("rst_valid_mid", 32'(instr_valid), 32'h0);
        chk("rst_pc_mid", 32'(pc), 32'h00);

        IR_enable = 1'b1; step(); IR_enable = 1'b0;
        repeat (TO - 1) step();
        chk("to_req_held", 32'(imem_req), 32'h1);
        step();
        if (TO_EN) begin
            chk("to_req_drop", 32'(imem_req), 32'h0);
            chk("to_err", 32'(fetch_err), 32'h1);
            chk("to_valid", 32'(instr_valid), 32'h0);
            fetch(16'h1234);
            chk("to_err_sticky", 32'(fetch_err), 32'h1);
            chk("to_refetch", 32'(instr), 32'h1234);
        end else begin
            chk("noto_req", 32'(imem_req), 32'h1);
            chk("noto_err", 32'(fetch_err), 32'h0);
            imem_ack = 1'b1; imem_rdata = 16'h4321; step(); imem_ack = 1'b0;
            chk("noto_instr", 32'(instr), 32'h4321);
        end

        repeat (600) begin
            reset      = ($urandom_range(0, 59) != 0);
            PC_enable  = $urandom_range(0, 1) == 1;
            IR_enable  = $urandom_range(0, 2) == 0;
            branch     = $urandom_range(0, 1) == 1;
            jump       = $urandom_range(0, 5) == 0;
            zero       = $urandom_range(0, 1) == 1;
            imem_ack   = $urandom_range(0, 3) == 0;
            imem_rdata = {($urandom_range(0, 1) == 1) ? 4'h7 + 4'($urandom_range(0, 1)) : 4'($urandom), 12'($urandom)};
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
